// File: rtl/servo_pwm_writer_if.sv
// Command port and Avalon-MM write bus between the duty controller, the
// writer and the Servo modulator's register slave.
interface servo_pwm_writer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_duty0;
    logic [15:0] cmd_duty1;
    logic [15:0] cmd_duty2;
    logic [15:0] cmd_maxctr;
    logic        cmd_maxctr_en;
    logic [3:0]  avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic        done;

    modport master (
        input  cmd_valid, cmd_duty0, cmd_duty1, cmd_duty2, cmd_maxctr, cmd_maxctr_en,
        input  avm_waitrequest,
        output cmd_ready, avm_address, avm_write, avm_writedata, done
    );

    modport slave (
        output cmd_valid, cmd_duty0, cmd_duty1, cmd_duty2, cmd_maxctr, cmd_maxctr_en,
        output avm_waitrequest,
        input  cmd_ready, avm_address, avm_write, avm_writedata, done
    );
endinterface

// File: rtl/servo_pwm_writer.sv
// Avalon-MM master that initialises the Servo modulator's mode registers and then
// writes dead-time-separated compare pairs plus the update strobe per duty command.
module servo_pwm_writer #(
    parameter int unsigned DEADTIME     = 16,
    parameter logic        UPDATE_ON0   = 1'b1,
    parameter logic        UPDATE_ONMAX = 1'b0,
    parameter logic        TRIG_ON0     = 1'b1,
    parameter logic        TRIG_ONMAX   = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    servo_pwm_writer_if.master  bus
);

    typedef enum logic [1:0] {INIT, IDLE, WRITE, FIN} state_t;

    localparam logic [16:0] DT = 17'(DEADTIME);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] cmp_q [6];
    logic [15:0] cmp_d [6];
    logic [15:0] maxctr_q, maxctr_d;
    logic        maxctr_en_q, maxctr_en_d;

    logic        write_q, write_d;
    logic [3:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        accepted;

    function automatic logic [15:0] sat_low(input logic [15:0] d);
        logic [16:0] x;
        x = {1'b0, d};
        return (x > DT) ? 16'(x - DT) : '0;
    endfunction

    function automatic logic [15:0] sat_high(input logic [15:0] d);
        logic [16:0] s;
        s = {1'b0, d} + DT;
        return (s > 17'h0FFFF) ? 16'hFFFF : s[15:0];
    endfunction

    assign accepted = write_q & ~bus.avm_waitrequest;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cmp_d       = cmp_q;
        maxctr_d    = maxctr_q;
        maxctr_en_d = maxctr_en_q;

        case (state_q)
            INIT: begin
                if (accepted) begin
                    if (idx_q == 3'd3) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            IDLE: begin
                if (bus.cmd_valid && ready_q) begin
                    state_d     = WRITE;
                    idx_d       = '0;
                    cmp_d[0]    = sat_low(bus.cmd_duty0);
                    cmp_d[1]    = sat_high(bus.cmd_duty0);
                    cmp_d[2]    = sat_low(bus.cmd_duty1);
                    cmp_d[3]    = sat_high(bus.cmd_duty1);
                    cmp_d[4]    = sat_low(bus.cmd_duty2);
                    cmp_d[5]    = sat_high(bus.cmd_duty2);
                    maxctr_d    = bus.cmd_maxctr;
                    maxctr_en_d = bus.cmd_maxctr_en;
                end
            end
            WRITE: begin
                if (accepted) begin
                    case (idx_q)
                        3'd5:    idx_d = maxctr_en_q ? 3'd6 : 3'd7;
                        3'd7: begin
                            state_d = FIN;
                            idx_d   = '0;
                        end
                        default: idx_d = idx_q + 3'd1;
                    endcase
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = INIT;
        endcase

        // Outputs are registered from the next state so they hold through stalls
        // and read as idle while reset is asserted.
        write_d = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        ready_d = 1'b0;
        done_d  = 1'b0;

        case (state_d)
            INIT: begin
                write_d = 1'b1;
                case (idx_d[1:0])
                    2'd0: begin addr_d = 4'hA; data_d = {15'b0, UPDATE_ON0};   end
                    2'd1: begin addr_d = 4'hB; data_d = {15'b0, UPDATE_ONMAX}; end
                    2'd2: begin addr_d = 4'hC; data_d = {15'b0, TRIG_ON0};     end
                    default: begin addr_d = 4'hD; data_d = {15'b0, TRIG_ONMAX}; end
                endcase
            end
            IDLE: ready_d = 1'b1;
            WRITE: begin
                write_d = 1'b1;
                case (idx_d)
                    3'd0: begin addr_d = 4'h0; data_d = cmp_d[0]; end
                    3'd1: begin addr_d = 4'h1; data_d = cmp_d[1]; end
                    3'd2: begin addr_d = 4'h2; data_d = cmp_d[2]; end
                    3'd3: begin addr_d = 4'h3; data_d = cmp_d[3]; end
                    3'd4: begin addr_d = 4'h4; data_d = cmp_d[4]; end
                    3'd5: begin addr_d = 4'h5; data_d = cmp_d[5]; end
                    3'd6: begin addr_d = 4'h8; data_d = maxctr_d; end
                    default: begin addr_d = 4'hF; data_d = 16'd1; end
                endcase
            end
            FIN:     done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT;
            idx_q       <= '0;
            cmp_q       <= '{default: '0};
            maxctr_q    <= '0;
            maxctr_en_q <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cmp_q       <= cmp_d;
            maxctr_q    <= maxctr_d;
            maxctr_en_q <= maxctr_en_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign bus.avm_write     = write_q;
    assign bus.avm_address   = addr_q;
    assign bus.avm_writedata = {16'h0000, data_q};
    assign bus.cmd_ready     = ready_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_servo_pwm_writer.sv
// Randomized bench for servo_pwm_writer: a write-list model predicts every Avalon
// write, the done pulse and cmd_ready, with optional random waitrequest stalls.
module tb_servo_pwm_writer;

    localparam int DT = 16;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk;
    logic reset_n;
    servo_pwm_writer_if bus();

    servo_pwm_writer #(
        .DEADTIME    (DT),
        .UPDATE_ON0  (1'b1),
        .UPDATE_ONMAX(1'b0),
        .TRIG_ON0    (1'b1),
        .TRIG_ONMAX  (1'b0)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t expq[$];
    logic mon_en, stall_en;
    logic idle_exp, done_exp;
    logic stall_prev;
    logic [3:0]  held_a;
    logic [31:0] held_d;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int low_of(input int d);
        return (d > DT) ? d - DT : 0;
    endfunction

    function automatic int high_of(input int d);
        return (d + DT > 65535) ? 65535 : d + DT;
    endfunction

    function automatic wr_t mk(input int a, input int d);
        wr_t w;
        w.a = 4'(a);
        w.d = 32'(d);
        return w;
    endfunction

    // Expected write list for one command, straight from the register map.
    task automatic push_cmd(input int d0, input int d1, input int d2, input int mx, input bit en);
        int d[3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        for (int k = 0; k < 3; k++) begin
            expq.push_back(mk(2 * k, low_of(d[k])));
            expq.push_back(mk(2 * k + 1, high_of(d[k])));
        end
        if (en) expq.push_back(mk(8, mx));
        expq.push_back(mk(15, 1));
    endtask

    // Bus monitor and reference model, sampled on the falling edge.
    initial begin
        logic nxt_idle, nxt_done, acc;
        wr_t  e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                acc = bus.avm_write && !bus.avm_waitrequest;
                check_eq("cmd_ready", bus.cmd_ready, idle_exp);
                check_eq("done", bus.done, done_exp);
                check_eq("write_active", bus.avm_write, expq.size() != 0);
                if (bus.avm_write) check_eq("wdata_hi", bus.avm_writedata[31:16], 0);
                if (stall_prev) begin
                    check_eq("stall_write", bus.avm_write, 1);
                    check_eq("stall_addr", bus.avm_address, held_a);
                    check_eq("stall_data", bus.avm_writedata, held_d);
                end
                nxt_idle = idle_exp;
                nxt_done = 1'b0;
                if (acc && expq.size() != 0) begin
                    e = expq.pop_front();
                    check_eq("wr_addr", bus.avm_address, e.a);
                    check_eq("wr_data", bus.avm_writedata, e.d);
                    if (e.a == 4'hF) nxt_done = 1'b1;
                    if (e.a == 4'hD) nxt_idle = 1'b1;
                end
                if (done_exp) nxt_idle = 1'b1;
                if (idle_exp && bus.cmd_valid) begin
                    push_cmd(bus.cmd_duty0, bus.cmd_duty1, bus.cmd_duty2,
                             bus.cmd_maxctr, bus.cmd_maxctr_en);
                    nxt_idle = 1'b0;
                end
                stall_prev = bus.avm_write && bus.avm_waitrequest;
                held_a     = bus.avm_address;
                held_d     = bus.avm_writedata;
                idle_exp   = nxt_idle;
                done_exp   = nxt_done;
            end
        end
    end

    // Slave stall generator: runs of at most three waitrequest cycles.
    initial begin
        int run;
        run = 0;
        bus.avm_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (stall_en && run < 3 && $urandom_range(0, 2) == 0) begin
                bus.avm_waitrequest = 1'b1;
                run++;
            end else begin
                bus.avm_waitrequest = 1'b0;
                run = 0;
            end
        end
    end

    task automatic release_reset();
        @(negedge clk);
        #1;
        expq.delete();
        expq.push_back(mk(10, 1));
        expq.push_back(mk(11, 0));
        expq.push_back(mk(12, 1));
        expq.push_back(mk(13, 0));
        idle_exp   = 1'b0;
        done_exp   = 1'b0;
        stall_prev = 1'b0;
        reset_n    = 1'b1;
        mon_en     = 1'b1;
    endtask

    task automatic issue_cmd(input int d0, input int d1, input int d2, input int mx, input bit en);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #2;
        bus.cmd_valid     = 1'b1;
        bus.cmd_duty0     = 16'(d0);
        bus.cmd_duty1     = 16'(d1);
        bus.cmd_duty2     = 16'(d2);
        bus.cmd_maxctr    = 16'(mx);
        bus.cmd_maxctr_en = en;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) got = 1'b1;
        end
        if (!got) check_eq("ready_timeout", bus.cmd_ready, 1);
        @(posedge clk);
        #2;
        // Scrambled, ignored inputs once the command is taken.
        bus.cmd_valid     = 1'b0;
        bus.cmd_duty0     = 16'($urandom);
        bus.cmd_duty1     = 16'($urandom);
        bus.cmd_duty2     = 16'($urandom);
        bus.cmd_maxctr    = 16'($urandom);
        bus.cmd_maxctr_en = 1'($urandom);
    endtask

    task automatic wait_done(input int exp_lat);
        int  k;
        bit  got;
        k   = 0;
        got = 1'b0;
        while (k < 300 && !got) begin
            @(negedge clk);
            k++;
            if (bus.done) got = 1'b1;
        end
        if (!got) check_eq("done_timeout", bus.done, 1);
        else if (exp_lat > 0) check_eq("done_latency", k, exp_lat);
    endtask

    function automatic int rnd_duty();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 40));
            1:       return int'($urandom_range(16'hFFD0, 16'hFFFF));
            default: return int'($urandom_range(0, 16'hFFFF));
        endcase
    endfunction

    initial begin
        bit seen;
        int en;
        mon_en            = 1'b0;
        stall_en          = 1'b0;
        stall_prev        = 1'b0;
        idle_exp          = 1'b0;
        done_exp          = 1'b0;
        reset_n           = 1'b0;
        bus.cmd_valid     = 1'b0;
        bus.cmd_duty0     = '0;
        bus.cmd_duty1     = '0;
        bus.cmd_duty2     = '0;
        bus.cmd_maxctr    = '0;
        bus.cmd_maxctr_en = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_write", bus.avm_write, 0);
        check_eq("rst_addr", bus.avm_address, 0);
        check_eq("rst_data", bus.avm_writedata, 0);
        check_eq("rst_ready", bus.cmd_ready, 0);
        check_eq("rst_done", bus.done, 0);

        release_reset();
        issue_cmd(1000, 16'h8000, 500, 0, 1'b0);
        wait_done(8);
        issue_cmd(8, 16'hFFF8, 123, 16'h5555, 1'b0);
        wait_done(8);
        issue_cmd(300, 400, 500, 16'h0FA0, 1'b1);
        wait_done(9);
        issue_cmd(0, 16'hFFFF, DT, 16'hFFFF, 1'b1);
        wait_done(9);

        stall_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            issue_cmd(rnd_duty(), rnd_duty(), rnd_duty(), int'($urandom_range(0, 16'hFFFF)),
                      1'($urandom));
            wait_done(0);
        end
        stall_en = 1'b0;
        repeat (2) @(posedge clk);

        // Abort a command in the middle of its 0x3 write.
        issue_cmd(2000, 3000, 4000, 16'h1234, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.avm_write && bus.avm_address == 4'h3) seen = 1'b1;
        end
        if (!seen) check_eq("addr3_seen", bus.avm_address, 3);
        #1;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_write", bus.avm_write, 0);
        check_eq("async_rst_addr", bus.avm_address, 0);
        check_eq("async_rst_ready", bus.cmd_ready, 0);
        repeat (2) @(posedge clk);
        release_reset();
        en = int'($urandom_range(0, 1));
        issue_cmd(rnd_duty(), rnd_duty(), rnd_duty(), 16'h0ABC, 1'(en));
        wait_done(en != 0 ? 9 : 8);
        repeat (3) @(negedge clk);
        check_eq("queue_empty", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
